// File: rtl/vram_pixel_fetch_if.sv
// Pixel-stream and VGA read-port signals of the VRAM pixel fetcher.
// The master modport is the fetch engine: it drives the RAM address and
// presents pixels. The slave modport is the surroundings: the display
// consumer plus the data RAM that answers a_vga with vram_i.
interface vram_pixel_fetch_if #(
  parameter int ADDR_W = 17,
  parameter int LANES  = 6,
  parameter int N      = 8
);
  logic                      frame_start;
  logic                      pix_req;
  logic [ADDR_W-1:0]         a_vga;
  logic [LANES-1:0][N-1:0]   vram_i;
  logic [N-1:0]              pix_data;
  logic                      pix_valid;
  logic                      frame_done;
  logic                      underrun;

  modport master (
    input  frame_start,
    input  pix_req,
    input  vram_i,
    output a_vga,
    output pix_data,
    output pix_valid,
    output frame_done,
    output underrun
  );

  modport slave (
    output frame_start,
    output pix_req,
    output vram_i,
    input  a_vga,
    input  pix_data,
    input  pix_valid,
    input  frame_done,
    input  underrun
  );
endinterface

// File: rtl/vram_pixel_fetch.sv
// Prefetching pixel streamer: reads packed LANES x N words from the frame
// region of data memory into a two-word ping-pong buffer and presents one
// pixel per request in raster order, lane 0 first.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, nothing issued, requests ignored
// RUN   | frame in progress: prefetch words, serve pixels
// DONE  | last pixel consumed; no reads, requests ignored until restart
module vram_pixel_fetch #(
  parameter int ADDR_W     = 17,
  parameter int LANES      = 6,
  parameter int N          = 8,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_PIXELS = 65536
) (
  input  logic               clk,
  input  logic               reset,
  vram_pixel_fetch_if.master bus
);

  localparam int NUM_WORDS = (NUM_PIXELS + LANES - 1) / LANES;
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PCNT_W    = $clog2(NUM_PIXELS + 1);
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [PCNT_W-1:0] LAST_PIX  = PCNT_W'(NUM_PIXELS - 1);
  localparam logic [WCNT_W-1:0] WORDS_TOT = WCNT_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef logic [LANES-1:0][N-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_vga_q, a_vga_d;
  logic [WCNT_W-1:0]   words_issued_q, words_issued_d;
  logic [1:0]          rd_v_q, rd_v_d;
  word_t               cur_q, cur_d;
  word_t               nxt_q, nxt_d;
  logic                cur_v_q, cur_v_d;
  logic                nxt_v_q, nxt_v_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [N-1:0]        pix_data_q, pix_data_d;
  logic                pix_valid_q, pix_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                underrun_q, underrun_d;

  logic [2:0]          occupancy;
  logic                consume;
  logic                last_pix;
  logic                issue;

  // Next-state logic: restart, consume/swap, capture, then prefetch issue.
  always_comb begin
    state_d        = state_q;
    a_vga_d        = a_vga_q;
    words_issued_d = words_issued_q;
    rd_v_d         = {rd_v_q[0], 1'b0};
    cur_d          = cur_q;
    nxt_d          = nxt_q;
    cur_v_d        = cur_v_q;
    nxt_v_d        = nxt_v_q;
    lane_d         = lane_q;
    pix_cnt_d      = pix_cnt_q;
    frame_done_d   = 1'b0;
    underrun_d     = underrun_q;
    consume        = 1'b0;
    last_pix       = 1'b0;
    issue          = 1'b0;

    // Words held plus words on their way back; the capture slot is
    // reserved at issue time so a returning word always has room.
    occupancy = {2'b00, cur_v_q} + {2'b00, nxt_v_q}
              + {2'b00, rd_v_q[0]} + {2'b00, rd_v_q[1]};

    if (bus.frame_start) begin
      // Restart wins over everything, including a same-cycle request.
      // Clearing rd_v drops any word still returning from the old frame.
      state_d        = ST_RUN;
      a_vga_d        = BASE;
      words_issued_d = WCNT_W'(1);
      rd_v_d         = 2'b01;
      cur_v_d        = 1'b0;
      nxt_v_d        = 1'b0;
      lane_d         = '0;
      pix_cnt_d      = '0;
      underrun_d     = 1'b0;
    end else if (state_q == ST_RUN) begin
      consume  = bus.pix_req && pix_valid_q;
      last_pix = (pix_cnt_q == LAST_PIX);

      if (bus.pix_req && !pix_valid_q) begin
        underrun_d = 1'b1;
      end

      if (consume) begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        lane_d    = lane_q + 1'b1;
        // End of word (or short last word): promote next into cur.
        if (lane_q == LAST_LANE || last_pix) begin
          lane_d  = '0;
          cur_d   = nxt_q;
          cur_v_d = nxt_v_q;
          nxt_v_d = 1'b0;
        end
        if (last_pix) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end
      end

      // Capture after the swap so a word arriving on a consume edge
      // lands in whichever slot the swap just freed.
      if (rd_v_q[1]) begin
        if (!cur_v_d) begin
          cur_d   = bus.vram_i;
          cur_v_d = 1'b1;
        end else begin
          nxt_d   = bus.vram_i;
          nxt_v_d = 1'b1;
        end
      end

      issue = (occupancy < 3'd2) && (words_issued_q < WORDS_TOT);
      if (issue) begin
        a_vga_d        = a_vga_q + 1'b1;
        words_issued_d = words_issued_q + 1'b1;
        rd_v_d[0]      = 1'b1;
      end
    end

    pix_valid_d = (state_d == ST_RUN) && cur_v_d;
    pix_data_d  = pix_valid_d ? cur_d[lane_d] : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      a_vga_q        <= BASE;
      words_issued_q <= '0;
      rd_v_q         <= '0;
      cur_q          <= '0;
      nxt_q          <= '0;
      cur_v_q        <= 1'b0;
      nxt_v_q        <= 1'b0;
      lane_q         <= '0;
      pix_cnt_q      <= '0;
      pix_data_q     <= '0;
      pix_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_vga_q        <= a_vga_d;
      words_issued_q <= words_issued_d;
      rd_v_q         <= rd_v_d;
      cur_q          <= cur_d;
      nxt_q          <= nxt_d;
      cur_v_q        <= cur_v_d;
      nxt_v_q        <= nxt_v_d;
      lane_q         <= lane_d;
      pix_cnt_q      <= pix_cnt_d;
      pix_data_q     <= pix_data_d;
      pix_valid_q    <= pix_valid_d;
      frame_done_q   <= frame_done_d;
      underrun_q     <= underrun_d;
    end
  end

  assign bus.a_vga      = a_vga_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_vram_pixel_fetch.sv
// Directed bench for vram_pixel_fetch: reset/idle, first words, full frame,
// DONE behaviour, underrun and mid-frame restart with a read in flight.
module tb_vram_pixel_fetch;

  localparam int ADDR_W     = 17;
  localparam int LANES      = 6;
  localparam int N          = 8;
  localparam int NUM_PIXELS = 65536;
  localparam int LAST_WORD  = 10922;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  int idle_bad;
  int pix_cnt;
  int pix_err;
  int fd_cnt;
  int max_a;
  int ur_seen;
  int done_bad;
  int done_fd;
  int done_a_bad;
  logic [ADDR_W-1:0] a_hold;

  vram_pixel_fetch_if #(.ADDR_W(ADDR_W), .LANES(LANES), .N(N)) bus ();

  vram_pixel_fetch #(
    .ADDR_W    (ADDR_W),
    .LANES     (LANES),
    .N         (N),
    .BASE_ADDR (0),
    .NUM_PIXELS(NUM_PIXELS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Frame content: pixel p holds (p+1) mod 256, so word w lane l = 6w+l+1.
  function automatic logic [LANES-1:0][N-1:0] mk_word(input logic [ADDR_W-1:0] a);
    logic [LANES-1:0][N-1:0] w;
    for (int l = 0; l < LANES; l++) w[l] = 8'(int'(a) * LANES + l + 1);
    return w;
  endfunction

  // Data RAM model: samples a_vga on an edge, answers during the next cycle.
  always @(posedge clk) bus.vram_i <= mk_word(bus.a_vga);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_req     = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset / idle
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.pix_valid !== 1'b0 || bus.pix_data !== 8'h00 || bus.frame_done !== 1'b0 ||
          bus.underrun !== 1'b0 || bus.a_vga !== 17'd0)
        idle_bad++;
    end
    check_eq("idle_bad_cycles", idle_bad, 0);
    check_eq("rst_a_vga", bus.a_vga, 0);
    check_eq("rst_pix_valid", bus.pix_valid, 0);
    check_eq("rst_pix_data", bus.pix_data, 0);
    check_eq("rst_frame_done", bus.frame_done, 0);
    check_eq("rst_underrun", bus.underrun, 0);

    // First frame: startup latency then back-to-back pixels
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    check_eq("fs_k0_a_vga", bus.a_vga, 0);
    check_eq("fs_k0_pix_valid", bus.pix_valid, 0);
    step();
    check_eq("fs_k1_a_vga", bus.a_vga, 1);
    check_eq("fs_k1_pix_valid", bus.pix_valid, 0);
    step();
    check_eq("fs_k2_pix_valid", bus.pix_valid, 1);
    bus.pix_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check_eq($sformatf("seq_pix_data_%0d", i), bus.pix_data, i + 1);
      check_eq($sformatf("seq_pix_valid_%0d", i), bus.pix_valid, 1);
      check_eq($sformatf("seq_a_vga_%0d", i), bus.a_vga, (i < 7) ? 1 : 2);
      step();
    end

    // Rest of the full frame with continuous requests
    pix_cnt = 12;
    pix_err = 0;
    fd_cnt  = 0;
    max_a   = 0;
    ur_seen = 0;
    for (int c = 0; c < 66000 && fd_cnt == 0; c++) begin
      if (bus.pix_valid === 1'b1) begin
        if (bus.pix_data !== 8'(pix_cnt + 1)) pix_err++;
        pix_cnt++;
      end
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (int'(bus.a_vga) > max_a) max_a = int'(bus.a_vga);
      if (bus.underrun !== 1'b0) ur_seen = 1;
      step();
    end
    check_eq("frame_pixel_count", pix_cnt, NUM_PIXELS);
    check_eq("frame_pixel_errors", pix_err, 0);
    check_eq("frame_done_pulses", fd_cnt, 1);
    check_eq("frame_max_a_vga", max_a, LAST_WORD);
    check_eq("frame_underrun", ur_seen, 0);
    check_eq("frame_done_one_cycle", bus.frame_done, 0);

    // DONE: requests ignored, no reads, no further frame_done
    a_hold     = bus.a_vga;
    done_bad   = 0;
    done_fd    = 0;
    done_a_bad = 0;
    for (int i = 0; i < 40; i++) begin
      bus.pix_req = (i % 2 == 0);
      step();
      if (bus.pix_valid !== 1'b0 || bus.pix_data !== 8'h00) done_bad++;
      if (bus.frame_done !== 1'b0) done_fd++;
      if (bus.a_vga !== a_hold) done_a_bad++;
    end
    check_eq("done_pix_outputs", done_bad, 0);
    check_eq("done_frame_done", done_fd, 0);
    check_eq("done_a_vga_moved", done_a_bad, 0);
    check_eq("done_a_vga", bus.a_vga, LAST_WORD);
    check_eq("done_underrun", bus.underrun, 0);

    // Underrun: request one cycle after restart, buffer still empty
    bus.pix_req     = 1'b0;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.pix_req     = 1'b1;
    step();
    check_eq("ur_set", bus.underrun, 1);
    check_eq("ur_k1_pix_valid", bus.pix_valid, 0);
    step();
    check_eq("ur_first_valid", bus.pix_valid, 1);
    check_eq("ur_first_pix", bus.pix_data, 8'h01);
    step();
    check_eq("ur_second_pix", bus.pix_data, 8'h02);
    check_eq("ur_sticky", bus.underrun, 1);
    repeat (6) step();
    check_eq("inflight_a_vga", bus.a_vga, 2);
    check_eq("inflight_pix", bus.pix_data, 8'h08);

    // Restart while word 2 is in flight; same-cycle request is dropped
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.pix_req     = 1'b0;
    check_eq("rs_underrun_clr", bus.underrun, 0);
    check_eq("rs_k0_pix_valid", bus.pix_valid, 0);
    check_eq("rs_k0_a_vga", bus.a_vga, 0);
    step();
    check_eq("rs_stale_dropped", bus.pix_valid, 0);
    check_eq("rs_k1_a_vga", bus.a_vga, 1);
    step();
    check_eq("rs_first_valid", bus.pix_valid, 1);
    check_eq("rs_first_pix", bus.pix_data, 8'h01);
    check_eq("rs_underrun", bus.underrun, 0);
    bus.pix_req = 1'b1;
    step();
    check_eq("rs_second_pix", bus.pix_data, 8'h02);
    check_eq("rs_underrun_after", bus.underrun, 0);
    bus.pix_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_pixel_fetch.md
# vram_pixel_fetch

Prefetching pixel streamer that sits between the data RAM's VGA read port and the VGA pixel path. It reads packed 6-lane, 8-bit words from the frame region of data memory and holds up to two words in a ping-pong buffer. Pixels are presented one per request in raster order, lane 0 first, so the display side sees a byte stream instead of a word-addressed memory. It drives the RAM's `a_vga` address and consumes the `vram` word that the RAM returns.

## Interface
Parameters:
- `ADDR_W`, 17: width of the VGA read address.
- `LANES`, 6: pixels per memory word.
- `N`, 8: bits per pixel/lane.
- `BASE_ADDR`, 0: word address of pixel 0.
- `NUM_PIXELS`, 65536: pixels per frame (256x256); needs ceil(NUM_PIXELS/LANES) = 10923 words.

Ports:
- `clk`  in  1: system clock. One clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `frame_start`  in  1: one-cycle pulse; (re)starts the frame at `BASE_ADDR`.
- `pix_req`  in  1: consumer takes the head pixel this cycle.
- `a_vga`  out  ADDR_W: word address to data RAM VGA port; registered.
- `vram_i`  in  LANES x N: word returned by data RAM; valid one cycle after `a_vga` is sampled.
- `pix_data`  out  N: head pixel; 0 when `pix_valid`=0.
- `pix_valid`  out  1: `pix_data` holds a real pixel.
- `frame_done`  out  1: one-cycle pulse when the last pixel is consumed.
- `underrun`  out  1: sticky; a request arrived while the buffer was empty mid-frame.

## Operation
- States:
  - IDLE: after reset.
  - RUN: frame in progress.
  - DONE: all pixels consumed.
- `frame_start` from any state:
  - Go to RUN.
  - Clear the buffer, the read pipe, `underrun`, the lane index and the pixel count.
  - Issue the read of `BASE_ADDR` on the same edge.
- Read tracking:
  - 2-stage valid pipe `rd_v`. An issue sets `rd_v[0]` and `rd_v[1]<=rd_v[0]`.
  - `vram_i` is captured into the buffer when `rd_v[1]`=1.
  - `frame_start` clears `rd_v`, so in-flight data from the aborted frame is dropped.
- Issue rule: in RUN, issue the next word (`a_vga<=a_vga+1`) when `buffered_words + inflight < 2` and words remain. At most one issue per cycle.
- Buffer: cur/next word registers with valid bits. The head pixel is `cur[lane_idx]`. `pix_valid` = cur valid and state RUN.
- Consume (`pix_req`=1 and `pix_valid`=1):
  - Increment the pixel count and `lane_idx`.
  - When `lane_idx` reaches LANES-1, or on the last pixel: `lane_idx<=0`, `cur<=next`, next becomes invalid. A capture on the same edge lands in the freed slot.
  - Capture and consume on the same edge must not lose data.
- Last word is partial: only lanes `0..(NUM_PIXELS-1)%LANES` are used (lanes 0..3 at defaults); the remaining lanes are ignored.
- End of frame:
  - Consuming pixel NUM_PIXELS-1 pulses `frame_done` for one cycle and moves to DONE.
  - In DONE: `pix_valid`=0, `pix_data`=0, requests are ignored, no reads are issued, `underrun` is unchanged.
- `pix_req` with `pix_valid`=0 in RUN: no consume; `underrun<=1`.
- `pix_req` in IDLE or DONE: ignored.
- `frame_start` and `pix_req` in the same cycle: `frame_start` wins and the request is dropped.

## Timing
- Reset values:
  - state IDLE.
  - `a_vga`=BASE_ADDR.
  - `pix_data`=0, `pix_valid`=0, `frame_done`=0, `underrun`=0.
  - buffers and `rd_v` invalid.
- Read latency: `a_vga` is updated at edge k, the RAM samples it at k+1, and the block captures at k+2.
- `frame_start` sampled at edge k:
  - `a_vga`=BASE from k.
  - `pix_valid`=1 from k+2.
  - Second word issued at k+1, captured at k+3.
- Sustained: continuous `pix_req` at one per cycle never underruns once `pix_valid` first rises. A word supplies 6 cycles of pixels against a 2-cycle refill.
- `frame_done` is asserted in the cycle after the edge that consumes the last pixel.

## Test plan
- Reset, then idle 10 cycles -> all outputs at reset values; `a_vga` holds BASE; no capture.
- Word 0 = {lane5..0} = {06,05,04,03,02,01}, word 1 = {0C..07}; `frame_start` at edge 0, then `pix_req` held high -> `pix_valid` rises at edge 2; `pix_data` reads 01..0C on consecutive cycles with no gap; `a_vga` steps 0,1,2,…
- Full 256x256 frame with continuous requests -> exactly 65536 valid pixels; last word uses lanes 0..3 only; `frame_done` pulses once; `a_vga` never exceeds 10922; `underrun` stays 0.
- Request asserted 1 cycle after `frame_start` (buffer still empty) -> `underrun`=1 and stays high; no pixel is skipped; the first consumed pixel is still 01.
- `frame_start` re-pulsed mid-frame while a read is in flight -> stale word discarded; the next valid pixel is pixel 0 (01); `underrun` cleared.
- In DONE, 20 `pix_req` pulses -> `pix_valid`=0, `pix_data`=0, no new `a_vga` issue, no further `frame_done`.
